// File: rtl/clock_pulse_gen.sv
// Multi-channel clock-enable generator: per-channel tick/phase dividers plus a
// data-triggered event pulse with a saturating event counter.
module clock_pulse_gen #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DIV_DEFAULT = 12,
  parameter int unsigned DATA_W      = 9,
  parameter int unsigned TRIG_BIT    = 8,
  parameter int unsigned EVENT_MODE  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [3:0]          load_ch,
  input  logic [WIDTH-1:0]    load_div,
  input  logic [DATA_W-1:0]   data,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] phase,
  output logic                event_pulse,
  output logic [WIDTH-1:0]    event_count
);

  localparam int unsigned CH_W    = 4;
  localparam bit          EDGE_EV = (EVENT_MODE != 0);

  logic [WIDTH-1:0] div_q [CHANNELS];
  logic [WIDTH-1:0] cnt_q [CHANNELS];
  logic             trig_q;
  logic             trig_c;
  logic             pulse_c;
  logic             unused_data_c;

  // Only the trigger bit matters; the rest of the word is intentionally ignored.
  assign unused_data_c = ^data;
  assign trig_c        = data[TRIG_BIT];
  assign pulse_c       = EDGE_EV ? (trig_c & ~trig_q) : trig_c;

  // Dividers: load beats stop, stop beats counting; load works with enable low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i] <= WIDTH'(DIV_DEFAULT);
        cnt_q[i] <= '0;
      end
      tick  <= '0;
      phase <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load && (load_ch == CH_W'(i))) begin
          div_q[i] <= load_div;
          cnt_q[i] <= '0;
          tick[i]  <= 1'b0;
        end else if (div_q[i] == '0) begin
          cnt_q[i] <= '0;
          tick[i]  <= 1'b0;
        end else if (enable && (cnt_q[i] == div_q[i] - WIDTH'(1))) begin
          cnt_q[i] <= '0;
          tick[i]  <= 1'b1;
          phase[i] <= ~phase[i];
        end else if (enable) begin
          cnt_q[i] <= cnt_q[i] + WIDTH'(1);
          tick[i]  <= 1'b0;
        end else begin
          tick[i]  <= 1'b0;
        end
      end
    end
  end

  // Event detector runs regardless of enable; counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_q      <= 1'b0;
      event_pulse <= 1'b0;
      event_count <= '0;
    end else begin
      trig_q      <= trig_c;
      event_pulse <= pulse_c;
      if (pulse_c && (event_count != '1)) begin
        event_count <= event_count + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_pulse_gen.sv
// Scoreboard bench for clock_pulse_gen: edge- and level-mode instances share
// stimulus; an elapsed-cycle reference model predicts every post-edge output.
module tb_clock_pulse_gen;
  localparam int unsigned CH   = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned DIVD = 12;
  localparam int unsigned DW   = 9;
  localparam int unsigned TB   = 8;
  localparam int          SAT  = (1 << W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, enable = 1'b0, load = 1'b0;
  logic [3:0]    load_ch = '0;
  logic [W-1:0]  load_div = '0;
  logic [DW-1:0] data = '0;
  logic [CH-1:0] tick1, phase1, tick0, phase0;
  logic          ep1, ep0;
  logic [W-1:0]  ec1, ec0;

  clock_pulse_gen #(.CHANNELS(CH), .WIDTH(W), .DIV_DEFAULT(DIVD), .DATA_W(DW),
                    .TRIG_BIT(TB), .EVENT_MODE(1)) u_edge (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_ch(load_ch),
    .load_div(load_div), .data(data), .tick(tick1), .phase(phase1),
    .event_pulse(ep1), .event_count(ec1));

  clock_pulse_gen #(.CHANNELS(CH), .WIDTH(W), .DIV_DEFAULT(DIVD), .DATA_W(DW),
                    .TRIG_BIT(TB), .EVENT_MODE(0)) u_level (
    .clk(clk), .reset(reset), .enable(enable), .load(load), .load_ch(load_ch),
    .load_div(load_div), .data(data), .tick(tick0), .phase(phase0),
    .event_pulse(ep0), .event_count(ec0));

  typedef struct {
    int            cyc;
    logic [CH-1:0] tick;
    logic [CH-1:0] phase;
    logic          ep1;
    logic [W-1:0]  ec1;
    logic          ep0;
    logic [W-1:0]  ec0;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model: per channel, enabled cycles since last restart and total ticks seen.
  int mdiv [CH];
  int mel  [CH];
  int mnt  [CH];
  bit mtrig;
  int mev1, mev0;
  int cyc;

  task automatic chk(input string name, input int c, input logic [63:0] act,
                     input logic [63:0] req);
    n_checks++;
    if (act !== req)
      $display("FAIL %s cycle %0d: got %h, expected %h", name, c, act, req);
    else
      n_pass++;
  endtask

  // Drive one cycle of inputs, then predict the outputs after that edge.
  task automatic step(input bit rst, input bit en, input bit ld, input int ch,
                      input int dv, input bit trig);
    exp_t e;
    reset    = rst;
    enable   = en;
    load     = ld;
    load_ch  = 4'(ch);
    load_div = W'(dv);
    data     = DW'($urandom);
    data[TB] = trig;
    @(posedge clk);
    e.tick = '0;
    e.phase = '0;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        mdiv[i] = DIVD; mel[i] = 0; mnt[i] = 0;
      end
      mtrig = 1'b0; mev1 = 0; mev0 = 0; cyc = 0;
      e.ep1 = 1'b0; e.ep0 = 1'b0;
    end else begin
      cyc++;
      for (int i = 0; i < CH; i++) begin
        if (ld && ch == i) begin
          mdiv[i] = dv; mel[i] = 0;
        end else if (mdiv[i] == 0) begin
          mel[i] = 0;
        end else if (en) begin
          mel[i]++;
          if (mel[i] % mdiv[i] == 0) begin
            e.tick[i] = 1'b1;
            mnt[i]++;
          end
        end
        e.phase[i] = (mnt[i] % 2 == 1);
      end
      e.ep0 = trig;
      e.ep1 = trig && !mtrig;
      mtrig = trig;
      mev0 += int'(e.ep0);
      mev1 += int'(e.ep1);
    end
    e.cyc = cyc;
    e.ec1 = W'((mev1 > SAT) ? SAT : mev1);
    e.ec0 = W'((mev0 > SAT) ? SAT : mev0);
    sb.push_back(e);
    #1;
  endtask

  task automatic run(input int n, input bit en);
    for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, 0, 0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, so each edge's prediction is consumed here.
  always @(negedge clk) begin
    if (sb.size() > 0) begin : mon
      exp_t e;
      e = sb.pop_front();
      chk("tick", e.cyc, 64'({tick1, tick0}), 64'({e.tick, e.tick}));
      chk("phase", e.cyc, 64'({phase1, phase0}), 64'({e.phase, e.phase}));
      chk("event_edge", e.cyc, 64'({ep1, ec1}), 64'({e.ep1, e.ec1}));
      chk("event_level", e.cyc, 64'({ep0, ec0}), 64'({e.ep0, e.ec0}));
    end
  end

  initial begin
    // Defaults after reset
    step(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    run(40, 1'b1);
    // Load ch1 div=3 at cycle 5, then an out-of-range load
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    run(4, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1, 3, 1'b0);
    run(15, 1'b1);
    step(1'b0, 1'b1, 1'b1, 7, 5, 1'b0);
    run(6, 1'b1);
    // Stop ch2, then divide by one; also a load with enable low
    step(1'b0, 1'b1, 1'b1, 2, 0, 1'b0);
    run(10, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2, 1, 1'b0);
    run(6, 1'b1);
    step(1'b0, 1'b0, 1'b1, 0, 2, 1'b0);
    run(3, 1'b0);
    run(6, 1'b1);
    // Enable low for cycles 6-9
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    run(5, 1'b1);
    run(4, 1'b0);
    run(12, 1'b1);
    // Event pattern: trigger high for cycles 3-7 and 10
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int c = 1; c <= 14; c++)
      step(1'b0, 1'b1, 1'b0, 0, 0, (c >= 3 && c <= 7) || c == 10);
    // Level-mode saturation
    for (int c = 0; c < 300; c++) step(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
    // Maximum divide value wraps without overflow
    step(1'b0, 1'b1, 1'b1, 3, SAT, 1'b0);
    run(520, 1'b1);
    // Reset during counting with a coincident load and trigger
    step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    run(19, 1'b1);
    step(1'b1, 1'b1, 1'b1, 0, 3, 1'b1);
    run(15, 1'b1);
    // Randomised traffic
    for (int k = 0; k < 3000; k++) begin
      int dv;
      dv = ($urandom_range(0, 19) == 0) ? SAT : int'($urandom_range(0, 9));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)), dv,
           1'($urandom));
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", cyc, 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
